// File: rtl/race_pkg.sv
// Shared race definitions: player identifiers, race FSM states and the position-width helper.
package race_pkg;

  localparam int NUM_PLAYERS = 4;

  localparam logic [1:0] PLAYER_GREEN  = 2'd0;
  localparam logic [1:0] PLAYER_RED    = 2'd1;
  localparam logic [1:0] PLAYER_BLUE   = 2'd2;
  localparam logic [1:0] PLAYER_YELLOW = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RACING   = 2'd1,
    ST_FINISHED = 2'd2
  } race_state_t;

  function automatic int pos_width(input int max_pos);
    return (max_pos > 2) ? $clog2(max_pos) : 1;
  endfunction

endpackage

// File: rtl/player_step_counter.sv
// One player's rising-edge step counter, saturating at the finish position.
// Optional per-player press cooldown when ANTI_MASH_EN is defined.
module player_step_counter
  import race_pkg::*;
#(
  parameter int MAX_POS      = 109,
  parameter int COOLDOWN_CYC = 50000,
  localparam int POS_W       = pos_width(MAX_POS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             step_en,
  input  logic             clear,
  output logic [POS_W-1:0] pos,
  output logic             at_finish,
  output logic             reach_finish
);

  localparam logic [POS_W-1:0] FINISH     = POS_W'(MAX_POS - 1);
  localparam logic [POS_W-1:0] PRE_FINISH = POS_W'(MAX_POS - 2);

  logic             btn_q_reg;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic             press, step, cd_idle;

  // Edge register runs in every state so a held button never yields a late step.
  assign press = btn & ~btn_q_reg;

`ifdef ANTI_MASH_EN
  localparam int CD_W = (COOLDOWN_CYC > 2) ? $clog2(COOLDOWN_CYC) : 1;

  logic [CD_W-1:0] cd_reg, cd_next;

  assign cd_idle = (cd_reg == '0);

  always_comb begin
    cd_next = cd_reg;
    if (clear)
      cd_next = '0;
    else if (step)
      cd_next = CD_W'(COOLDOWN_CYC - 1);
    else if (!cd_idle)
      cd_next = cd_reg - CD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cd_reg <= '0;
    else
      cd_reg <= cd_next;
  end
`else
  assign cd_idle = 1'b1;
`endif

  assign step = press && step_en && cd_idle && (pos_reg != FINISH);

  always_comb begin
    pos_next = pos_reg;
    if (clear)
      pos_next = '0;
    else if (step)
      pos_next = pos_reg + POS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q_reg <= 1'b0;
      pos_reg   <= '0;
    end else begin
      btn_q_reg <= btn;
      pos_reg   <= pos_next;
    end
  end

  assign pos          = pos_reg;
  assign at_finish    = (pos_reg == FINISH);
  assign reach_finish = step && (pos_reg == PRE_FINISH);

endmodule

// File: rtl/player_position_tracker.sv
// Four-player race position tracker: race FSM, per-player step counters and winner latch.
// Build option: define ANTI_MASH_EN to enable the per-player press cooldown.
module player_position_tracker
  import race_pkg::*;
#(
  parameter int MAX_POS      = 109,
  parameter int COOLDOWN_CYC = 50000,
  localparam int POS_W       = pos_width(MAX_POS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_in_menu,
  input  logic             game_started,
  input  logic             btn_green,
  input  logic             btn_red,
  input  logic             btn_blue,
  input  logic             btn_yellow,
  output logic [POS_W-1:0] green_cur_pos,
  output logic [POS_W-1:0] red_cur_pos,
  output logic [POS_W-1:0] blue_cur_pos,
  output logic [POS_W-1:0] yellow_cur_pos,
  output logic             winner_valid,
  output logic [1:0]       winner_id
);

  race_state_t state_reg, state_next;

  logic [NUM_PLAYERS-1:0] btn_vec, at_finish, reach_finish;
  logic [POS_W-1:0]       pos_arr [NUM_PLAYERS];
  logic                   step_en, clear;
  logic                   winner_valid_reg, winner_valid_next;
  logic [1:0]             winner_id_reg, winner_id_next;

  assign btn_vec = {btn_yellow, btn_blue, btn_red, btn_green};

  // Once a winner exists nobody steps, even in the cycle before FINISHED is entered.
  assign step_en = (state_reg == ST_RACING) && game_started && !is_in_menu && !winner_valid_reg;
  assign clear   = is_in_menu || (state_reg == ST_IDLE);

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      player_step_counter #(
        .MAX_POS      (MAX_POS),
        .COOLDOWN_CYC (COOLDOWN_CYC)
      ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn_vec[gi]),
        .step_en      (step_en),
        .clear        (clear),
        .pos          (pos_arr[gi]),
        .at_finish    (at_finish[gi]),
        .reach_finish (reach_finish[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    if (is_in_menu) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:     if (game_started) state_next = ST_RACING;
        ST_RACING:   if (|at_finish) state_next = ST_FINISHED;
        ST_FINISHED: state_next = ST_FINISHED;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // Lowest-numbered finisher wins a tie; later assignments override earlier ones.
  always_comb begin
    winner_valid_next = winner_valid_reg;
    winner_id_next    = winner_id_reg;
    if (clear) begin
      winner_valid_next = 1'b0;
      winner_id_next    = 2'd0;
    end else if (|reach_finish) begin
      winner_valid_next = 1'b1;
      if (reach_finish[3]) winner_id_next = PLAYER_YELLOW;
      if (reach_finish[2]) winner_id_next = PLAYER_BLUE;
      if (reach_finish[1]) winner_id_next = PLAYER_RED;
      if (reach_finish[0]) winner_id_next = PLAYER_GREEN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      winner_valid_reg <= 1'b0;
      winner_id_reg    <= 2'd0;
    end else begin
      state_reg        <= state_next;
      winner_valid_reg <= winner_valid_next;
      winner_id_reg    <= winner_id_next;
    end
  end

  assign green_cur_pos  = pos_arr[0];
  assign red_cur_pos    = pos_arr[1];
  assign blue_cur_pos   = pos_arr[2];
  assign yellow_cur_pos = pos_arr[3];
  assign winner_valid   = winner_valid_reg;
  assign winner_id      = winner_id_reg;

endmodule
